sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Front end of the SHA-256 core. Accepts a message as a byte stream with a valid/ready handshake. Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. Emits 512-bit blocks with first/last flags. The downstream compression controller uses these blocks to drive M_in/input_valid and to select the initial hash value or chaining.

Parameters:
LEN_W, 64, width of the internal bit-length counter (legal 16..64); zero-extended into block bits 63:0.

Ports:
clk  in  1  clock
rst  in  1  reset
in_data  in  8  message byte
in_keep  in  1  1 = in_data is a real byte; 0 = no byte on this beat (only meaningful with in_last)
in_valid  in  1  beat valid
in_last  in  1  final beat of message
in_ready  out  1  beat accepted when in_valid && in_ready
blk_data  out  512  block; byte 0 at bits 511:504
blk_valid  out  1  block valid
blk_ready  in  1  block accepted when blk_valid && blk_ready
blk_first  out  1  first block of a message
blk_last  out  1  final (padded) block of a message

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - Reset values: state=FILL, byte index idx=0, length=0, buffer=0, blk_valid=0, blk_first=0, blk_last=0, blk_data=0, internal first_pend=1.
  - in_ready = (state==FILL) && !rst.
  - Reset mid-operation discards the partial message and any pending block.
- State FILL:
  - Accepted beat with in_keep=1: write the byte at buffer byte idx, idx++, length += 8 (wraps mod 2^LEN_W).
  - Accepted beat with in_keep=0 and in_last=0: consumed, no effect.
  - Byte at idx=63 with in_last=0: go to EMIT with the flags last=0, extra=0.
  - in_last accepted: go to PAD. p = final idx, 0..64; p=64 only when the last byte fills the block.
- State PAD (1 cycle):
  - p<=55: write 0x80 at byte p and length at bits 63:0. Go to EMIT, last=1, extra=0.
  - 56<=p<=63: write 0x80 at byte p. Go to EMIT, last=0, extra=1, extra80=0.
  - p=64: no write. Go to EMIT, last=0, extra=1, extra80=1.
- State EMIT:
  - blk_valid=1. blk_data, blk_first and blk_last are held stable until handshake.
  - blk_first = first_pend.
  - On handshake:
    - Clear the buffer to 0 and set idx=0.
    - first_pend <= blk_last.
    - If blk_last: clear length.
    - If extra: go to EXTRA. Otherwise go to FILL.
- State EXTRA (1 cycle):
  - Buffer is already zero.
  - Write 0x80 at byte 0 if extra80.
  - Write length at bits 63:0.
  - Go to EMIT with last=1, extra=0.
- Latency:
  - Full non-final block: blk_valid is asserted the cycle after the 64th byte is accepted.
  - Final block: blk_valid is asserted 2 cycles after the in_last beat.
  - Extra block: blk_valid is asserted 2 cycles after the preceding block's handshake.
- in_ready=0 in PAD/EMIT/EXTRA. No input byte is accepted while a block is pending (single buffer).
- blk_valid never deasserts without a handshake, except on rst.
- Length counter overflow wraps silently.
- Zero-length message: a single beat with in_last=1, in_keep=0 at idx=0. The resulting block is 0x80 followed by zeros, length 0.

Optional Feature:
SHA256_PAD_BLKCNT_EN:
- Defined: adds output port msg_blk_cnt[15:0], the 0-based index within the current message of the block on blk_data.
  - Increments on each handshake with blk_last=0.
  - Clears to 0 on a handshake with blk_last=1 and on rst.
  - Saturates at 16'hFFFF.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. "abc" (0x61,0x62,0x63, last on 0x63, keep=1):
   - One block, blk_valid 2 cycles after the last beat.
   - blk_data = 0x61626380 followed by zeros, low 64 bits = 0x18.
   - first=1, last=1.
2. Empty message (one beat, in_last=1, in_keep=0):
   - One block: 0x80 at byte 0, rest zero, length 0.
   - first=1, last=1.
3. 56 bytes of 0x00, last on byte 55:
   - Block 1: zeros with 0x80 at byte 56; first=1, last=0.
   - Block 2: all zero except bits 63:0 = 0x1C0; first=0, last=1.
   - With macro: msg_blk_cnt 0 then 1.
4. 64 bytes 0x00..0x3F, last on 0x3F:
   - Block 1: exactly the data; first=1, last=0.
   - Block 2: 0x80 at byte 0, length 0x200; last=1.
5. Backpressure: hold blk_ready=0 for 10 cycles during EMIT.
   - blk_valid=1 and blk_data/flags stable throughout.
   - in_ready=0 throughout.
   - Block is accepted on the first blk_ready=1 cycle.
6. Assert rst for 1 cycle after 30 bytes of a message, then send "abc":
   - Output is identical to scenario 1, including blk_first=1.
   - No stale bytes appear in the block.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: byte stream in, FIPS 180-4 padded 512-bit blocks out.
// Optional block index output enabled by defining SHA256_PAD_BLKCNT_EN.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [15:0]  msg_blk_cnt
`endif
);

    typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;

    state_t         state_q, state_d;
    logic [6:0]     idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [511:0]   buf_q, buf_d;
    logic           last_q, last_d;
    logic           extra_q, extra_d;
    logic           extra80_q, extra80_d;
    logic           first_pend_q, first_pend_d;

    logic           in_fire;
    logic           blk_fire;
    logic [5:0]     wr_pos;
    logic [63:0]    len_bits;

    assign in_ready  = (state_q == FILL) && !rst;
    assign blk_valid = (state_q == EMIT);
    assign blk_first = blk_valid && first_pend_q;
    assign blk_last  = blk_valid && last_q;
    assign blk_data  = buf_q;

    assign in_fire   = in_valid && in_ready;
    assign blk_fire  = blk_valid && blk_ready;
    // Byte 0 lives in the top byte lane, so the lane number counts down from 63.
    assign wr_pos    = 6'd63 - idx_q[5:0];
    assign len_bits  = 64'(len_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        buf_d        = buf_q;
        last_d       = last_q;
        extra_d      = extra_q;
        extra80_d    = extra80_q;
        first_pend_d = first_pend_q;

        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (in_keep) begin
                        buf_d[{wr_pos, 3'b000} +: 8] = in_data;
                        idx_d = idx_q + 7'd1;
                        len_d = len_q + LEN_W'(8);
                    end
                    if (in_last) begin
                        state_d = PAD;
                    end else if (in_keep && idx_q == 7'd63) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                        extra_d = 1'b0;
                    end
                end
            end
            PAD: begin
                state_d = EMIT;
                if (idx_q <= 7'd55) begin
                    buf_d[{wr_pos, 3'b000} +: 8] = 8'h80;
                    buf_d[63:0] = len_bits;
                    last_d  = 1'b1;
                    extra_d = 1'b0;
                end else if (idx_q <= 7'd63) begin
                    // No room for the length field: it goes into an extra block.
                    buf_d[{wr_pos, 3'b000} +: 8] = 8'h80;
                    last_d    = 1'b0;
                    extra_d   = 1'b1;
                    extra80_d = 1'b0;
                end else begin
                    last_d    = 1'b0;
                    extra_d   = 1'b1;
                    extra80_d = 1'b1;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    buf_d        = '0;
                    idx_d        = '0;
                    first_pend_d = last_q;
                    if (last_q) begin
                        len_d = '0;
                    end
                    state_d = extra_q ? EXTRA : FILL;
                end
            end
            EXTRA: begin
                if (extra80_q) begin
                    buf_d[511:504] = 8'h80;
                end
                buf_d[63:0] = len_bits;
                last_d  = 1'b1;
                extra_d = 1'b0;
                state_d = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            len_q        <= '0;
            buf_q        <= '0;
            last_q       <= 1'b0;
            extra_q      <= 1'b0;
            extra80_q    <= 1'b0;
            first_pend_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            last_q       <= last_d;
            extra_q      <= extra_d;
            extra80_q    <= extra80_d;
            first_pend_q <= first_pend_d;
        end
    end

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (blk_fire) begin
            if (last_q) begin
                blk_cnt_d = '0;
            end else if (blk_cnt_q != 16'hFFFF) begin
                blk_cnt_d = blk_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign msg_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed scenarios plus random messages checked
// against a queue-based FIPS 180-4 padding model.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0]  msg_blk_cnt;
`endif

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_first  (blk_first),
        .blk_last   (blk_last)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .msg_blk_cnt(msg_blk_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_blk_q[$];
    bit           exp_first_q[$];
    bit           exp_last_q[$];
    int           exp_idx_q[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit count.
    function automatic void build_exp();
        logic [7:0]   pb[$];
        logic [63:0]  bits;
        logic [511:0] b;
        int           nb;
        pb   = msg_q;
        bits = 64'(msg_q.size()) << 3;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
        nb = pb.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b = {b[503:0], pb[64*k + j]};
            exp_blk_q.push_back(b);
            exp_first_q.push_back(k == 0);
            exp_last_q.push_back(k == nb - 1);
            exp_idx_q.push_back(k);
        end
    endfunction

    task automatic run_msg(input bit tail_keep0, input int gap_pct, input int bp_pct, input string tag);
        int           nbeats;
        int           bi;
        int           cyc;
        bit           pend;
        bit           filler;
        logic [511:0] pdata;
        logic         pf;
        logic         pl;
        build_exp();
        nbeats = msg_q.size() + ((tail_keep0 || msg_q.size() == 0) ? 1 : 0);
        bi = 0; cyc = 0; pend = 0;
        while (exp_blk_q.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                chk({tag, " hold_valid"}, blk_valid, 1'b1);
                chk({tag, " hold_data"}, blk_data, pdata);
                chk({tag, " hold_flags"}, {blk_first, blk_last}, {pf, pl});
            end
            if (blk_valid) chk({tag, " in_ready_blocked"}, in_ready, 1'b0);
            filler = 0;
            if (bi < nbeats && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                if ($urandom_range(9) == 0) begin
                    in_keep = 1'b0; in_last = 1'b0; in_data = 8'($urandom); filler = 1;
                end else if (bi < msg_q.size()) begin
                    in_keep = 1'b1; in_last = (bi == nbeats - 1); in_data = msg_q[bi];
                end else begin
                    in_keep = 1'b0; in_last = 1'b1; in_data = 8'($urandom);
                end
            end else begin
                in_valid = 1'b0; in_keep = 1'($urandom); in_last = 1'b0; in_data = 8'($urandom);
            end
            blk_ready = ($urandom_range(99) >= bp_pct);
            if (in_valid && in_ready && !filler) bi++;
            pend = blk_valid && !blk_ready;
            pdata = blk_data; pf = blk_first; pl = blk_last;
            if (blk_valid && blk_ready) begin
                chk({tag, " data"}, blk_data, exp_blk_q[0]);
                chk({tag, " first"}, blk_first, exp_first_q[0]);
                chk({tag, " last"}, blk_last, exp_last_q[0]);
`ifdef SHA256_PAD_BLKCNT_EN
                chk({tag, " blk_cnt"}, msg_blk_cnt, 16'(exp_idx_q[0]));
`endif
                void'(exp_blk_q.pop_front());
                void'(exp_first_q.pop_front());
                void'(exp_last_q.pop_front());
                void'(exp_idx_q.pop_front());
            end
        end
        if (exp_blk_q.size() > 0) begin
            chk({tag, " timeout_blocks_left"}, exp_blk_q.size(), 0);
            exp_blk_q.delete(); exp_first_q.delete(); exp_last_q.delete(); exp_idx_q.delete();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle_after"}, blk_valid, 1'b0);
        $display("msg %s len=%0d tail_keep0=%0d checked", tag, msg_q.size(), tail_keep0);
    endtask

    // "abc" driven beat by beat to pin latency, then held under backpressure.
    task automatic abc_direct(input int hold, input string tag);
        logic [511:0] exp_b;
        exp_b = {32'h61626380, 416'h0, 64'h18};
        @(negedge clk); in_valid = 1; in_keep = 1; in_last = 0; in_data = 8'h61;
        @(negedge clk); in_data = 8'h62;
        @(negedge clk); in_data = 8'h63; in_last = 1;
        @(negedge clk); in_valid = 0; in_last = 0;
        chk({tag, " pad_cycle_valid"}, blk_valid, 1'b0);
        @(negedge clk);
        chk({tag, " valid"}, blk_valid, 1'b1);
        chk({tag, " data"}, blk_data, exp_b);
        chk({tag, " first_last"}, {blk_first, blk_last}, 2'b11);
`ifdef SHA256_PAD_BLKCNT_EN
        chk({tag, " blk_cnt"}, msg_blk_cnt, 16'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; in_keep = 1; in_data = 8'hEE; blk_ready = 0;
            @(negedge clk);
            chk({tag, " bp_valid"}, blk_valid, 1'b1);
            chk({tag, " bp_data"}, blk_data, exp_b);
            chk({tag, " bp_flags"}, {blk_first, blk_last}, 2'b11);
            chk({tag, " bp_in_ready"}, in_ready, 1'b0);
        end
        in_valid = 0; blk_ready = 1;
        @(negedge clk);
        blk_ready = 0;
        chk({tag, " accepted"}, blk_valid, 1'b0);
        chk({tag, " ready_again"}, in_ready, 1'b1);
        $display("abc %s hold=%0d checked", tag, hold);
    endtask

    initial begin
        rst = 1; in_data = 0; in_keep = 0; in_valid = 0; in_last = 0; blk_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset blk_valid", blk_valid, 1'b0);
        chk("reset flags", {blk_first, blk_last}, 2'b00);
        chk("reset blk_data", blk_data, 512'h0);
        chk("reset in_ready", in_ready, 1'b0);
        rst = 0;
        @(negedge clk);
        chk("post_reset in_ready", in_ready, 1'b1);

        abc_direct(0, "t1_abc");

        msg_q.delete();
        run_msg(0, 0, 0, "t2_empty");

        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'h00);
        run_msg(0, 0, 0, "t3_56zero");

        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
        run_msg(0, 0, 0, "t4_64seq");
        run_msg(1, 0, 30, "t4_64seq_keep0tail");

        abc_direct(10, "t5_backpressure");

        msg_q.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); in_valid = 1; in_keep = 1; in_last = 0; in_data = 8'($urandom_range(1, 255));
        end
        @(negedge clk); in_valid = 0; rst = 1;
        @(negedge clk);
        chk("t6 in_ready_in_reset", in_ready, 1'b0);
        rst = 0;
        abc_direct(0, "t6_after_reset");

        for (int n = 0; n < 25; n++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 150)); i++) msg_q.push_back(8'($urandom));
            run_msg(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 60), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
